pe_nic: RTL

PE_NIC -- requirements
Module: pe_nic

---
 rtl/pe_nic.sv | 87 ++++++++
 1 files changed

// File: rtl/pe_nic.sv
// Processor-side network interface: one-entry input and output packet channels
// between a processor register port and a router PE port, with polarity-gated injection.
module pe_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ri,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ro,
    input  logic [DATA_WIDTH-1:0] net_di,
    input  logic                  net_polarity
);

    localparam logic [1:0] ADDR_IN_BUF     = 2'd0;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'd2;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'd3;

    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  in_full;
    logic                  out_full;
    logic                  rd_en;
    logic                  wr_en;
    logic                  eject;
    logic                  inject;

    assign rd_en  = nicEn & ~nicWrEn;
    assign wr_en  = nicEn & nicWrEn;

    assign net_ro = ~in_full;
    assign net_do = out_buf;
    // The router only takes a packet whose VC matches its current polarity.
    assign net_so = out_full & (out_buf[DATA_WIDTH-1] == net_polarity);

    assign eject  = net_si & ~in_full;
    assign inject = net_so & net_ri;

    // Capture and drain are mutually exclusive: capture needs in_full=0, drain needs in_full=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (eject) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end else if (rd_en && addr == ADDR_IN_BUF && in_full) begin
            in_full <= 1'b0;
        end
    end

    // out_full is sampled before the drain, so a write on the draining edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (inject) begin
            out_full <= 1'b0;
        end else if (wr_en && addr == ADDR_OUT_BUF && !out_full) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            case (addr)
                ADDR_IN_BUF:     d_out <= in_buf;
                ADDR_IN_STATUS:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_BUF:    d_out <= out_buf;
                ADDR_OUT_STATUS: d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:         d_out <= in_buf;
            endcase
        end
    end

endmodule
